// File: rtl/lock_seq_pkg.sv
// Shared types and constants for the combination-lock sequencer.
// Codes are written in entry order: the first digit entered is the most significant nibble.
package lock_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_PROGRAM = 3'd4,
    S_FAIL    = 3'd5,
    S_LOCKOUT = 3'd6
  } state_e;

  localparam logic [1:0] PB_NONE  = 2'b00;
  localparam logic [1:0] PB_SHORT = 2'b01;
  localparam logic [1:0] PB_LONG  = 2'b10;

  localparam int DIG_IDX_W  = 2;
  localparam int MAX_DIGITS = 4;

  // Swaps between entry order (first digit at the top) and display order (digit 0 at [3:0]).
  // The mapping is its own inverse, so it serves both directions.
  function automatic logic [15:0] rev_digits(input logic [15:0] v, input int n);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < MAX_DIGITS; i++)
      if (i < n) r[4*i +: 4] = v[4*(n-1-i) +: 4];
    return r;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; done_o is high for the single cycle the count sits at zero after a load.
module lock_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] count_q;
  logic         run_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      run_q   <= 1'b0;
    end else if (load_i) begin
      count_q <= load_val_i;
      run_q   <= 1'b1;
    end else if (run_q) begin
      if (count_q == '0) run_q   <= 1'b0;
      else               count_q <= count_q - W'(1);
    end
  end

  assign done_o = run_q && (count_q == '0);

endmodule

// File: rtl/lock_seq_ctrl.sv
// Combination-lock sequencer: code entry, compare, unlock, reprogramming, fail hold and lockout.
// Display outputs are computed from next-state values so they line up with state_o.
module lock_seq_ctrl
  import lock_seq_pkg::*;
#(
  parameter int          NUM_DIGITS     = 4,
  parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
  parameter int          MAX_TRIES      = 3,
  parameter logic [23:0] FAIL_CYCLES    = 24'd6_000_000,
  parameter logic [27:0] LOCKOUT_CYCLES = 28'd120_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  enc,
  input  logic [1:0]  pb_press_type,
  output logic [15:0] digits,
  output logic [3:0]  digit_en,
  output logic [1:0]  cursor,
  output logic [2:0]  state_o,
  output logic        unlocked,
  output logic        fail,
  output logic        alarm
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam logic [27:0] TMR_MAX = (28'(FAIL_CYCLES) > LOCKOUT_CYCLES) ?
                                    28'(FAIL_CYCLES) : LOCKOUT_CYCLES;
  localparam int TMR_W = (TMR_MAX > 28'd1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] FAIL_LOAD = TMR_W'(FAIL_CYCLES - 24'd1);
  localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCKOUT_CYCLES - 28'd1);
  localparam logic [15:0] CODE_MASK = 16'((32'd1 << (4*NUM_DIGITS)) - 32'd1);
  localparam logic [3:0]  EN_MASK   = 4'((32'd1 << NUM_DIGITS) - 32'd1);
  localparam logic [DIG_IDX_W-1:0] LAST = DIG_IDX_W'(NUM_DIGITS - 1);
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  state_e               state_q, state_d;
  logic [15:0]          buf_q, buf_d;
  logic [15:0]          code_q, code_d;
  logic [DIG_IDX_W-1:0] cur_q, cur_d;
  logic [TRY_W-1:0]     tries_q, tries_d;
  logic [15:0]          digits_q, digits_d;
  logic [3:0]           den_q, den_d;
  logic                 unl_q, unl_d, fail_q, fail_d, alarm_q, alarm_d;
  logic                 tmr_load, tmr_done;
  logic [TMR_W-1:0]     tmr_val;
  logic                 short_p, long_p;

  assign short_p = (pb_press_type == PB_SHORT);
  assign long_p  = (pb_press_type == PB_LONG);

  lock_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    cur_d    = cur_q;
    code_d   = code_q;
    tries_d  = tries_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      S_IDLE: if (short_p) begin
        buf_d   = '0;
        cur_d   = '0;
        state_d = S_ENTRY;
      end
      S_ENTRY, S_PROGRAM: begin
        if (short_p) begin
          buf_d[{cur_q, 2'b00} +: 4] = enc;
          if (cur_q == LAST) begin
            if (state_q == S_ENTRY) state_d = S_CHECK;
            else begin
              code_d  = rev_digits(buf_d, NUM_DIGITS) & CODE_MASK;
              state_d = S_IDLE;
            end
          end else begin
            cur_d = cur_q + DIG_IDX_W'(1);
          end
        end else if (long_p) begin
          buf_d   = '0;
          state_d = (state_q == S_ENTRY) ? S_IDLE : S_OPEN;
        end
      end
      S_CHECK: begin
        if (buf_q == rev_digits(code_q, NUM_DIGITS)) begin
          tries_d = '0;
          state_d = S_OPEN;
        end else if (tries_q == LAST_TRY) begin
          tmr_load = 1'b1;
          tmr_val  = LOCK_LOAD;
          state_d  = S_LOCKOUT;
        end else begin
          if (tries_q != '1) tries_d = tries_q + TRY_W'(1);
          tmr_load = 1'b1;
          tmr_val  = FAIL_LOAD;
          state_d  = S_FAIL;
        end
      end
      S_OPEN: begin
        if (short_p) state_d = S_IDLE;
        else if (long_p) begin
          cur_d   = '0;
          buf_d   = '0;
          state_d = S_PROGRAM;
        end
      end
      S_FAIL: if (tmr_done) state_d = S_IDLE;
      S_LOCKOUT: if (tmr_done) begin
        tries_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Display: buffer with the cursor slot following enc live, or the stored code when open.
  always_comb begin
    digits_d = '0;
    den_d    = '0;
    case (state_d)
      S_ENTRY, S_PROGRAM: begin
        digits_d = buf_d;
        digits_d[{cur_d, 2'b00} +: 4] = enc;
        for (int i = 0; i < MAX_DIGITS; i++)
          den_d[i] = (DIG_IDX_W'(i) <= cur_d);
      end
      S_OPEN: begin
        digits_d = rev_digits(code_d, NUM_DIGITS);
        den_d    = 4'hF;
      end
      default: ;
    endcase
    digits_d = digits_d & CODE_MASK;
    den_d    = den_d & EN_MASK;
    unl_d    = (state_d == S_OPEN) || (state_d == S_PROGRAM);
    fail_d   = (state_d == S_FAIL);
    alarm_d  = (state_d == S_LOCKOUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      buf_q    <= '0;
      code_q   <= DEFAULT_CODE & CODE_MASK;
      cur_q    <= '0;
      tries_q  <= '0;
      digits_q <= '0;
      den_q    <= '0;
      unl_q    <= 1'b0;
      fail_q   <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      code_q   <= code_d;
      cur_q    <= cur_d;
      tries_q  <= tries_d;
      digits_q <= digits_d;
      den_q    <= den_d;
      unl_q    <= unl_d;
      fail_q   <= fail_d;
      alarm_q  <= alarm_d;
    end
  end

  assign digits   = digits_q;
  assign digit_en = den_q;
  assign cursor   = cur_q;
  assign state_o  = state_q;
  assign unlocked = unl_q;
  assign fail     = fail_q;
  assign alarm    = alarm_q;

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// Directed bench for lock_seq_ctrl: entry, fail, lockout, reprogram, aborts, reset and reserved presses.
module tb_lock_seq_ctrl;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_ENTRY = 3'd1, ST_CHECK = 3'd2, ST_OPEN = 3'd3,
                         ST_PROG = 3'd4, ST_FAIL = 3'd5, ST_LOCK = 3'd6;
  localparam logic [1:0] P_NONE = 2'b00, P_SHORT = 2'b01, P_LONG = 2'b10, P_RSVD = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  enc = 4'd0;
  logic [1:0]  pb  = 2'b00;
  logic [15:0] digits;
  logic [3:0]  digit_en;
  logic [1:0]  cursor;
  logic [2:0]  state_o;
  logic        unlocked, fail, alarm;
  int          checks = 0;
  int          errors = 0;

  lock_seq_ctrl #(
    .NUM_DIGITS(4), .DEFAULT_CODE(16'h1234), .MAX_TRIES(3),
    .FAIL_CYCLES(24'd8), .LOCKOUT_CYCLES(28'd20)
  ) dut (
    .clk(clk), .rst(rst), .enc(enc), .pb_press_type(pb),
    .digits(digits), .digit_en(digit_en), .cursor(cursor), .state_o(state_o),
    .unlocked(unlocked), .fail(fail), .alarm(alarm)
  );

  always #5 clk = ~clk;

  // One-cycle press; returns at the negedge after the consuming posedge.
  task automatic press(input logic [1:0] t);
    @(negedge clk); pb = t;
    @(negedge clk); pb = P_NONE;
  endtask

  // c is in display order: digit 0 (entered first) at [3:0].
  task automatic enter_code(input logic [15:0] c);
    press(P_SHORT);
    for (int i = 0; i < 4; i++) begin
      enc = c[4*i +: 4];
      press(P_SHORT);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (state_o !== ST_IDLE && n < 100) begin
      @(negedge clk); n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (state_o !== ST_IDLE) begin errors++; $display("FAIL rst_state got=%0d exp=%0d", state_o, ST_IDLE); end
    checks++; if (digits !== 16'h0) begin errors++; $display("FAIL rst_digits got=%h exp=0000", digits); end
    checks++; if (digit_en !== 4'h0 || cursor !== 2'd0) begin errors++; $display("FAIL rst_en_cur got=%b/%0d exp=0000/0", digit_en, cursor); end
    checks++; if ({unlocked, fail, alarm} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", {unlocked, fail, alarm}); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (state_o !== ST_IDLE) begin errors++; $display("FAIL rst_release got=%0d exp=0", state_o); end
  endtask

  task automatic test_correct();
    press(P_SHORT);
    checks++; if (state_o !== ST_ENTRY || cursor !== 2'd0 || digit_en !== 4'b0001) begin errors++; $display("FAIL corr_start got=%0d/%0d/%b exp=1/0/0001", state_o, cursor, digit_en); end
    for (int i = 1; i <= 4; i++) begin
      enc = 4'(i);
      press(P_SHORT);
    end
    checks++; if (state_o !== ST_CHECK) begin errors++; $display("FAIL corr_check got=%0d exp=2", state_o); end
    @(negedge clk);
    checks++; if (state_o !== ST_OPEN || unlocked !== 1'b1) begin errors++; $display("FAIL corr_open got=%0d/%b exp=3/1", state_o, unlocked); end
    checks++; if (digits !== 16'h4321 || digit_en !== 4'hF) begin errors++; $display("FAIL corr_digits got=%h/%b exp=4321/1111", digits, digit_en); end
    press(P_SHORT);
    checks++; if (state_o !== ST_IDLE || unlocked !== 1'b0 || digit_en !== 4'h0) begin errors++; $display("FAIL corr_relock got=%0d/%b/%b exp=0/0/0000", state_o, unlocked, digit_en); end
  endtask

  task automatic test_wrong();
    int n = 0;
    enter_code(16'h5321);
    checks++; if (state_o !== ST_CHECK) begin errors++; $display("FAIL wrong_check got=%0d exp=2", state_o); end
    @(negedge clk);
    checks++; if (state_o !== ST_FAIL || fail !== 1'b1 || unlocked !== 1'b0) begin errors++; $display("FAIL wrong_fail got=%0d/%b exp=5/1", state_o, fail); end
    while (fail === 1'b1 && n < 40) begin
      n++; @(negedge clk);
    end
    checks++; if (n != 8) begin errors++; $display("FAIL wrong_len got=%0d exp=8", n); end
    checks++; if (state_o !== ST_IDLE) begin errors++; $display("FAIL wrong_idle got=%0d exp=0", state_o); end
  endtask

  task automatic test_abort_entry();
    press(P_SHORT);
    enc = 4'd7; press(P_SHORT);
    enc = 4'd8; press(P_SHORT);
    checks++; if (cursor !== 2'd2 || digits !== 16'h0887 || digit_en !== 4'b0111) begin errors++; $display("FAIL abort_mid got=%0d/%h/%b exp=2/0887/0111", cursor, digits, digit_en); end
    press(P_LONG);
    checks++; if (state_o !== ST_IDLE || digits !== 16'h0 || digit_en !== 4'h0) begin errors++; $display("FAIL abort_entry got=%0d/%h/%b exp=0/0000/0000", state_o, digits, digit_en); end
  endtask

  // Try counter is 1 from test_wrong and must have survived the entry abort.
  task automatic test_lockout();
    int n = 0;
    enter_code(16'h0000);
    @(negedge clk);
    checks++; if (state_o !== ST_FAIL) begin errors++; $display("FAIL lock_second got=%0d exp=5", state_o); end
    wait_idle();
    enter_code(16'h9999);
    @(negedge clk);
    checks++; if (state_o !== ST_LOCK || alarm !== 1'b1 || fail !== 1'b0) begin errors++; $display("FAIL lock_enter got=%0d/%b/%b exp=6/1/0", state_o, alarm, fail); end
    while (alarm === 1'b1 && n < 60) begin
      n++;
      pb = (n == 3) ? P_SHORT : (n == 5) ? P_LONG : (n == 7) ? P_RSVD : P_NONE;
      @(negedge clk);
    end
    pb = P_NONE;
    checks++; if (n != 20) begin errors++; $display("FAIL lock_len got=%0d exp=20", n); end
    checks++; if (state_o !== ST_IDLE || alarm !== 1'b0) begin errors++; $display("FAIL lock_exit got=%0d/%b exp=0/0", state_o, alarm); end
    enter_code(16'h7777);
    @(negedge clk);
    checks++; if (state_o !== ST_FAIL) begin errors++; $display("FAIL lock_tries_clr got=%0d exp=5", state_o); end
    wait_idle();
    enter_code(16'h4321);
    @(negedge clk);
    checks++; if (state_o !== ST_OPEN) begin errors++; $display("FAIL lock_reopen got=%0d exp=3", state_o); end
    press(P_SHORT);
  endtask

  task automatic test_abort_program();
    enter_code(16'h4321);
    @(negedge clk);
    press(P_LONG);
    checks++; if (state_o !== ST_PROG || unlocked !== 1'b1 || cursor !== 2'd0 || digit_en !== 4'b0001) begin errors++; $display("FAIL prog_enter got=%0d/%b/%0d/%b exp=4/1/0/0001", state_o, unlocked, cursor, digit_en); end
    enc = 4'd9; press(P_SHORT);
    checks++; if (cursor !== 2'd1) begin errors++; $display("FAIL prog_cursor got=%0d exp=1", cursor); end
    press(P_LONG);
    checks++; if (state_o !== ST_OPEN || digits !== 16'h4321 || unlocked !== 1'b1) begin errors++; $display("FAIL prog_abort got=%0d/%h/%b exp=3/4321/1", state_o, digits, unlocked); end
    press(P_SHORT);
  endtask

  task automatic test_reprogram();
    enter_code(16'h4321);
    @(negedge clk);
    press(P_LONG);
    for (int i = 0; i < 4; i++) begin
      enc = 4'(10 + i);
      press(P_SHORT);
    end
    checks++; if (state_o !== ST_IDLE || unlocked !== 1'b0) begin errors++; $display("FAIL reprog_done got=%0d/%b exp=0/0", state_o, unlocked); end
    enter_code(16'h4321);
    @(negedge clk);
    checks++; if (state_o !== ST_FAIL) begin errors++; $display("FAIL reprog_old got=%0d exp=5", state_o); end
    wait_idle();
    enter_code(16'hDCBA);
    @(negedge clk);
    checks++; if (state_o !== ST_OPEN || digits !== 16'hDCBA) begin errors++; $display("FAIL reprog_new got=%0d/%h exp=3/dcba", state_o, digits); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); rst = 1'b1;
    #1;
    checks++; if (state_o !== ST_IDLE || unlocked !== 1'b0 || digits !== 16'h0 || digit_en !== 4'h0) begin errors++; $display("FAIL rstmid_async got=%0d/%b/%h/%b exp=0/0/0000/0000", state_o, unlocked, digits, digit_en); end
    @(negedge clk); rst = 1'b0;
    enter_code(16'h4321);
    @(negedge clk);
    checks++; if (state_o !== ST_OPEN || digits !== 16'h4321) begin errors++; $display("FAIL rstmid_default got=%0d/%h exp=3/4321", state_o, digits); end
  endtask

  task automatic test_reserved();
    press(P_RSVD);
    checks++; if (state_o !== ST_OPEN) begin errors++; $display("FAIL rsvd_open got=%0d exp=3", state_o); end
    press(P_SHORT);
    press(P_RSVD);
    checks++; if (state_o !== ST_IDLE) begin errors++; $display("FAIL rsvd_idle got=%0d exp=0", state_o); end
    press(P_SHORT);
    enc = 4'd1; press(P_SHORT);
    press(P_RSVD);
    checks++; if (state_o !== ST_ENTRY || cursor !== 2'd1) begin errors++; $display("FAIL rsvd_entry got=%0d/%0d exp=1/1", state_o, cursor); end
    enc = 4'd2; press(P_SHORT);
    enc = 4'd3; press(P_SHORT);
    enc = 4'd5; press(P_SHORT);
    @(negedge clk);
    press(P_RSVD);
    checks++; if (state_o !== ST_FAIL) begin errors++; $display("FAIL rsvd_fail got=%0d exp=5", state_o); end
    wait_idle();
    enter_code(16'h4321);
    @(negedge clk);
    press(P_LONG);
    press(P_RSVD);
    checks++; if (state_o !== ST_PROG || cursor !== 2'd0) begin errors++; $display("FAIL rsvd_prog got=%0d/%0d exp=4/0", state_o, cursor); end
    press(P_LONG);
    press(P_SHORT);
  endtask

  task automatic test_live_enc();
    enc = 4'd3;
    press(P_SHORT);
    checks++; if (digits !== 16'h0003 || digit_en !== 4'b0001) begin errors++; $display("FAIL live_start got=%h/%b exp=0003/0001", digits, digit_en); end
    enc = 4'd9;
    @(negedge clk);
    checks++; if (digits !== 16'h0009) begin errors++; $display("FAIL live_d0 got=%h exp=0009", digits); end
    press(P_SHORT);
    checks++; if (digits !== 16'h0099 || digit_en !== 4'b0011 || cursor !== 2'd1) begin errors++; $display("FAIL live_latch got=%h/%b/%0d exp=0099/0011/1", digits, digit_en, cursor); end
    enc = 4'd6;
    @(negedge clk);
    checks++; if (digits !== 16'h0069) begin errors++; $display("FAIL live_d1 got=%h exp=0069", digits); end
    press(P_LONG);
    checks++; if (state_o !== ST_IDLE) begin errors++; $display("FAIL live_abort got=%0d exp=0", state_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_correct();
    test_wrong();
    test_abort_entry();
    test_lockout();
    test_abort_program();
    test_reprogram();
    test_reset_mid();
    test_reserved();
    test_live_enc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lock_seq_ctrl.md
Name: lock_seq_ctrl

Overview:
Combination-lock sequencer for the rotary-encoder / seven-segment front end. Takes the 4-bit encoder count and debounced push-button press events and runs code entry, comparison, unlock, code reprogramming, failure display and brute-force lockout. Drives the digit values and cursor consumed by the seven-segment multiplexer, plus lock status flags. Sits between rotational_encoder and seven_seg in the top level.

Parameters:
NUM_DIGITS, 4, code length in hex digits (2..4)
DEFAULT_CODE, 16'h1234, code register value after reset (low NUM_DIGITS*4 bits used)
MAX_TRIES, 3, consecutive wrong entries that trigger lockout (1..7)
FAIL_CYCLES, 24'd6_000_000, clk cycles the FAIL indication is held
LOCKOUT_CYCLES, 28'd120_000_000, clk cycles the LOCKOUT is held

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active high
enc  in  4  current encoder count; selects the digit being edited
pb_press_type  in  2  00 none, 01 short, 10 long, 11 reserved (ignored); non-zero for exactly one clk per press
digits  out  16  digit values, digit i on [4i+3:4i]
digit_en  out  4  per-digit display enable; 0 means blank
cursor  out  2  index of the digit being edited
state_o  out  3  FSM state encoding
unlocked  out  1  high in OPEN and PROGRAM
fail  out  1  high in FAIL
alarm  out  1  high in LOCKOUT

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active high. All state and outputs are registered.
- Reset values: state IDLE; digits 0; digit_en 0; cursor 0; unlocked/fail/alarm 0; try counter 0; timer 0; code register DEFAULT_CODE; entry buffer 0.
- States: IDLE=0, ENTRY=1, CHECK=2, OPEN=3, PROGRAM=4, FAIL=5, LOCKOUT=6.
- IDLE: digit_en=0. A short press clears the buffer, sets cursor=0 and goes to ENTRY. A long press is ignored.
- ENTRY/PROGRAM display:
  - digits shows the buffer, with buffer[cursor] replaced live by enc.
  - digit_en enables digits 0..cursor only.
- ENTRY/PROGRAM short press: latch enc into buffer[cursor].
  - If cursor==NUM_DIGITS-1: ENTRY goes to CHECK; PROGRAM writes the full buffer, including the just-latched digit, into the code register in the same cycle and goes to IDLE.
  - Otherwise cursor increments.
- ENTRY/PROGRAM long press: abort. ENTRY goes to IDLE; PROGRAM goes to OPEN. The code register is unchanged and the buffer is cleared.
- CHECK: lasts exactly 1 cycle and ignores inputs. Compare the buffer with the code (low NUM_DIGITS*4 bits).
  - Match: go to OPEN, tries=0.
  - Mismatch, tries+1==MAX_TRIES: go to LOCKOUT, timer loaded.
  - Mismatch otherwise: tries++, go to FAIL, timer loaded.
- Press-to-state latency: a final short press in ENTRY puts state_o=CHECK on the next cycle; OPEN/FAIL/LOCKOUT follows one cycle later.
- OPEN: unlocked=1; digits shows the code, all enabled.
  - Short press: relock, go to IDLE.
  - Long press: cursor=0, clear buffer, go to PROGRAM.
- FAIL: fail=1; timer counts down from FAIL_CYCLES-1. On reaching 0, go to IDLE. Presses are ignored.
- LOCKOUT: alarm=1; timer counts down from LOCKOUT_CYCLES-1. On reaching 0, tries=0 and go to IDLE. Presses are ignored.
- Try counter width is $clog2(MAX_TRIES+1). It saturates and never wraps. It resets only on a correct code, at LOCKOUT exit, or on rst.
- Digits at or above NUM_DIGITS are always disabled and read 0.
- pb_press_type=11 is treated as none in every state.
- rst mid-operation immediately returns the block to reset values. A programmed code is lost (not retained).

Decomposition:
- Package lock_seq_pkg:
  - state enum.
  - press-type constants PB_NONE/PB_SHORT/PB_LONG.
  - Digit-index width.
- One sub-module, lock_timer: a loadable down-counter with a `done` pulse, shared by FAIL and LOCKOUT. Width is sized by $clog2 of the larger cycle parameter.
- The FSM, buffer, code register and try counter stay in lock_seq_ctrl.

Test Plan:
Bench parameters: NUM_DIGITS=4, FAIL_CYCLES=8, LOCKOUT_CYCLES=20, MAX_TRIES=3.
1. Correct code: short press; then for enc=1,2,3,4 a short press each. Expect CHECK for 1 cycle, then OPEN with unlocked=1 and digits=16'h4321 (digit0=1). A short press then returns to IDLE with unlocked=0.
2. Wrong code: enter 1,2,3,5. Expect FAIL with fail=1 for 8 cycles, then IDLE. The try counter is now 1.
3. Lockout: three wrong entries. After the third CHECK, expect alarm=1 for 20 cycles. Presses during lockout have no effect. Then IDLE, and the next correct code opens.
4. Reprogram: open with 1234, long press, enter A,B,C,D. Expect IDLE. Entering 1234 fails; entering ABCD opens.
5. Aborts: long press after 2 digits in ENTRY gives IDLE, buffer 0, try counter unchanged. Long press in PROGRAM gives OPEN with the code still 1234.
6. Reset and edges: assert rst in OPEN after reprogramming; expect all outputs at reset values and DEFAULT_CODE restored. Apply pb_press_type=11 in every state; expect no transition. Check that a live enc change in ENTRY updates digits[4*cursor+:4] on the next cycle.
